// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF  = 36;
  localparam int unsigned INSTR_W_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; storage is not reset, head is only meaningful when not empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  input  logic                         i_clear,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign o_full  = (o_count == CW'(DEPTH));
  assign o_empty = (o_count == '0);
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);
  assign o_data  = mem[rd_ptr];

  // Data storage write port.
  always_ff @(posedge i_clk) begin
    if (do_push && !i_clear)
      mem[wr_ptr] <= i_data;
  end

  // Pointer and occupancy tracking; pointers wrap naturally as DEPTH is a power of 2.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else if (i_clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + PW'(1);
      o_count <= o_count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order reads at the PC, queues returned words with their PC.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_flush,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic               o_pc_en,
  output logic               o_mem_req_valid,
  input  logic               i_mem_req_ready,
  output logic [ADDR_W-1:0]  o_mem_req_addr,
  input  logic               i_mem_rsp_valid,
  input  logic [INSTR_W-1:0] i_mem_rsp_data,
  output logic               o_instr_valid,
  input  logic               i_instr_ready,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_instr_pc
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_state_t state;
  fetch_state_t state_nx;

  logic [CW-1:0]             outstanding;
  logic [CW-1:0]             drop_cnt;
  logic [CW-1:0]             iq_count;
  logic [CW:0]               in_use;
  logic                      credit_ok;
  logic [ADDR_W-1:0]         tag_head;
  logic [INSTR_W+ADDR_W-1:0] iq_head;
  logic                      iq_push;
  logic                      iq_empty;
  logic                      iq_full;
  logic                      tq_full;
  logic                      tq_empty;
  logic                      unused_ok;

  assign unused_ok = &{1'b0, iq_full, tq_full, tq_empty};

  // The in-flight count is the tag queue occupancy: one tag per issued, unanswered request.
  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (o_pc_en),
    .i_data  (i_pc),
    .i_pop   (i_mem_rsp_valid),
    .i_clear (1'b0),
    .o_data  (tag_head),
    .o_full  (tq_full),
    .o_empty (tq_empty),
    .o_count (outstanding)
  );

  fetch_fifo #(
    .WIDTH (INSTR_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (iq_push),
    .i_data  ({i_mem_rsp_data, tag_head}),
    .i_pop   (i_instr_ready),
    .i_clear (i_flush),
    .o_data  (iq_head),
    .o_full  (iq_full),
    .o_empty (iq_empty),
    .o_count (iq_count)
  );

  assign in_use         = {1'b0, outstanding} + {1'b0, iq_count};
  assign credit_ok      = (in_use < (CW+1)'(DEPTH));
  assign o_mem_req_addr = i_pc;
  assign iq_push        = i_mem_rsp_valid && (drop_cnt == '0) && !i_flush;

  assign o_instr_valid  = !iq_empty;
  assign {o_instr, o_instr_pc} = iq_empty ? '0 : iq_head;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next state and request issue; flush freezes the state and blocks issue.
  always_comb begin
    state_nx        = state;
    o_mem_req_valid = 1'b0;
    o_pc_en         = 1'b0;
    if (!i_flush) begin
      case (state)
        IDLE: begin
          if (i_en)
            state_nx = FETCH;
        end
        FETCH: begin
          if (!i_en)
            state_nx = IDLE;
          o_mem_req_valid = credit_ok;
          o_pc_en         = credit_ok && i_mem_req_ready;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Count of in-flight responses that belong to fetches discarded by a flush.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      drop_cnt <= '0;
    else if (i_flush)
      drop_cnt <= outstanding - CW'(i_mem_rsp_valid);
    else if (i_mem_rsp_valid && (drop_cnt != '0))
      drop_cnt <= drop_cnt - CW'(1);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model, scoreboard, vector table and corner sequences.
module tb_fetch_unit;

  localparam int unsigned ADDR_W  = 36;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned DEPTH   = 4;

  logic               clk           = 1'b0;
  logic               rst_n         = 1'b0;
  logic               en            = 1'b0;
  logic               flush         = 1'b0;
  logic [ADDR_W-1:0]  i_pc          = '0;
  logic               mem_req_ready = 1'b1;
  logic               rsp_valid     = 1'b0;
  logic [INSTR_W-1:0] rsp_data      = '0;
  logic               instr_ready   = 1'b0;
  logic               o_pc_en;
  logic               o_mem_req_valid;
  logic [ADDR_W-1:0]  o_mem_req_addr;
  logic               o_instr_valid;
  logic [INSTR_W-1:0] o_instr;
  logic [ADDR_W-1:0]  o_instr_pc;

  fetch_unit #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_en            (en),
    .i_flush         (flush),
    .i_pc            (i_pc),
    .o_pc_en         (o_pc_en),
    .o_mem_req_valid (o_mem_req_valid),
    .i_mem_req_ready (mem_req_ready),
    .o_mem_req_addr  (o_mem_req_addr),
    .i_mem_rsp_valid (rsp_valid),
    .i_mem_rsp_data  (rsp_data),
    .o_instr_valid   (o_instr_valid),
    .i_instr_ready   (instr_ready),
    .o_instr         (o_instr),
    .o_instr_pc      (o_instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [INSTR_W-1:0] data; logic [ADDR_W-1:0] pc; } exp_t;
  typedef struct { logic [ADDR_W-1:0] pc; bit dead; } tag_t;
  typedef struct { bit en; bit dready; bit exp_req; bit exp_iv; } vec_t;

  exp_t              expq[$];
  tag_t              inflt[$];
  tag_t              t;
  bit                st_m;
  bit                pc_adv;
  bit                exp_req;
  bit                issue;
  int                lat = 2;
  bit                pv[8];
  logic [ADDR_W-1:0] pa[8];
  int                vecs = 0;
  int                fails = 0;
  int                issue_total = 0;
  int                deliver_total = 0;
  vec_t              tbl[13];

  function automatic logic [INSTR_W-1:0] mdata(input logic [ADDR_W-1:0] a);
    return 32'hA000_0000 + a[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pc_adv)
      i_pc = i_pc + 36'd1;
  endtask

  task automatic do_reset(input bit e);
    rst_n       = 1'b0;
    flush       = 1'b0;
    en          = e;
    instr_ready = 1'b0;
    i_pc        = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_pc  = '0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_instr_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ivalid"}, o_instr_valid, 0);
    chk({tag, "_req"},    o_mem_req_valid, 0);
    chk({tag, "_pc_en"},  o_pc_en, 0);
    chk({tag, "_instr"},  o_instr, 0);
    chk({tag, "_ipc"},    o_instr_pc, 0);
  endtask

  // Memory model (fixed latency, in-order) and scoreboard, evaluated mid-cycle.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      expq.delete();
      inflt.delete();
      st_m          = 1'b0;
      pc_adv        = 1'b0;
      rsp_valid     = 1'b0;
      issue_total   = 0;
      deliver_total = 0;
      for (int i = 0; i < 8; i++) pv[i] = 1'b0;
    end else begin
      exp_req = st_m && !flush && ((inflt.size() + expq.size()) < DEPTH);
      chk("req_valid", o_mem_req_valid, exp_req);
      chk("pc_en", o_pc_en, exp_req && mem_req_ready);
      issue = o_mem_req_valid && mem_req_ready;
      if (issue)
        chk("req_addr", o_mem_req_addr, i_pc);
      chk("instr_valid", o_instr_valid, expq.size() != 0);
      if (o_instr_valid && expq.size() != 0) begin
        chk("instr_data", o_instr, expq[0].data);
        chk("instr_pc", o_instr_pc, expq[0].pc);
      end
      chk("credit_invariant", (dut.outstanding + dut.iq_count) <= DEPTH, 1);

      rsp_valid = pv[lat-1];
      rsp_data  = mdata(pa[lat-1]);
      for (int i = 7; i > 0; i--) begin
        pv[i] = pv[i-1];
        pa[i] = pa[i-1];
      end
      pv[0] = issue;
      pa[0] = i_pc;

      pc_adv = o_pc_en;
      if (o_instr_valid && instr_ready && expq.size() != 0) begin
        void'(expq.pop_front());
        deliver_total++;
      end
      if (flush) begin
        foreach (inflt[i]) inflt[i].dead = 1'b1;
        expq.delete();
      end
      if (rsp_valid) begin
        chk("rsp_has_outstanding", inflt.size() != 0, 1);
        if (inflt.size() != 0) begin
          t = inflt.pop_front();
          if (!t.dead)
            expq.push_back('{data: mdata(t.pc), pc: t.pc});
        end
      end
      if (issue) begin
        inflt.push_back('{pc: i_pc, dead: 1'b0});
        issue_total++;
      end
      if (!flush)
        st_m = en;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int nv;
    int np;

    // Decode stalled after reset release: fill to DEPTH, then one credit per pop.
    tbl[0]  = '{1, 0, 0, 0};
    tbl[1]  = '{1, 0, 1, 0};
    tbl[2]  = '{1, 0, 1, 0};
    tbl[3]  = '{1, 0, 1, 0};
    tbl[4]  = '{1, 0, 1, 1};
    tbl[5]  = '{1, 0, 0, 1};
    tbl[6]  = '{1, 0, 0, 1};
    tbl[7]  = '{1, 0, 0, 1};
    tbl[8]  = '{1, 1, 0, 1};
    tbl[9]  = '{1, 0, 1, 1};
    tbl[10] = '{1, 0, 0, 1};
    tbl[11] = '{1, 0, 0, 1};
    tbl[12] = '{1, 0, 0, 1};

    // Reset held with fetch enabled.
    lat   = 2;
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_outputs_zero("reset");
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      en          = tbl[i].en;
      instr_ready = tbl[i].dready;
      @(negedge clk);
      chk($sformatf("tbl%0d_req", i), o_mem_req_valid, tbl[i].exp_req);
      chk($sformatf("tbl%0d_ivalid", i), o_instr_valid, tbl[i].exp_iv);
      tick();
    end

    // Sustained streaming with decode always ready.
    instr_ready = 1'b1;
    repeat (12) tick();
    nv = 0;
    np = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_instr_valid) nv++;
      if (o_pc_en) np++;
      tick();
    end
    chk("stream_valid_cycles", nv, 20);
    chk("stream_pc_en_cycles", np, 20);

    // Flush with 2 in flight and 2 queued, one response coincident; redirect to 0x100.
    lat = 2;
    do_reset(1'b1);
    instr_ready = 1'b0;
    repeat (5) tick();
    chk("flush_setup_queued", dut.iq_count, 2);
    chk("flush_setup_outst", dut.outstanding, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    i_pc  = 36'h100;
    @(negedge clk);
    chk("flush_valid_clear", o_instr_valid, 0);
    chk("flush_drop_cnt", dut.drop_cnt, 1);
    instr_ready = 1'b1;
    tick();
    wait_valid(ok);
    chk("redirect_seen", ok, 1);
    if (ok) begin
      chk("redirect_pc", o_instr_pc, 36'h100);
      chk("redirect_data", o_instr, 32'hA000_0100);
    end
    tick();

    // Flush coincident with the only outstanding response.
    do_reset(1'b1);
    instr_ready = 1'b1;
    tick();
    en = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("no_stale_valid", o_instr_valid, 0);
      tick();
    end
    chk("flush1_drop_cnt", dut.drop_cnt, 0);
    chk("flush1_outst", dut.outstanding, 0);
    chk("flush1_issues", issue_total, 1);

    // Enable dropped with 3 requests outstanding (3-cycle memory).
    lat = 3;
    do_reset(1'b1);
    instr_ready = 1'b1;
    tick();
    tick();
    tick();
    en = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    chk("en_off_req", o_mem_req_valid, 0);
    chk("en_off_issues", issue_total, 3);
    chk("en_off_delivered", deliver_total, 3);

    // Asynchronous reset in the middle of a burst.
    lat = 2;
    do_reset(1'b1);
    instr_ready = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    chk("burst_valid", o_instr_valid, 1);
    chk("burst_req", o_mem_req_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_pc  = '0;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
